// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Each cycle at most one
// requester is granted; its operands and opcode are steered onto the ALU
// ports and the ALU result is captured into a one-entry response buffer on
// the same clock edge. Contention is resolved with a 1-bit round-robin
// pointer. The response buffer is drained through a valid/ready handshake
// and can be refilled on the same edge it drains, giving one result per
// cycle.
//
// ALU control encoding shared with the ALU:
//   0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 SLT, 0x6 LTU,
//   0x7 SLL, 0x8 SRL, 0x9 SRA, 0xF NOP. Other codes are forwarded as-is.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req{0,1}_valid / _ready       request handshake per requester
//   req{0,1}_in1 / _in2           32-bit operands per requester
//   req{0,1}_control              4-bit opcode per requester
//   alu_in1, alu_in2, alu_control drive the shared ALU
//   alu_out                       combinational ALU result
//   rsp_valid, rsp_id, rsp_data   buffered response (id = winning requester)
//   rsp_ready                     consumer accepts the response
// ---------------------------------------------------------------------------
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [3:0]  req0_control,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [3:0]  req1_control,

  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_out,

  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready
);

  localparam logic [3:0] ALU_NOP = 4'hF;

  logic        full;
  logic        buf_id;
  logic [31:0] buf_data;
  logic        prio;

  logic        accept_ok;
  logic        grant_valid;
  logic        grant_id;

  // The buffer can take a new result if it is empty or is being drained on
  // this same edge; this is the only path from rsp_ready, and it feeds the
  // grant side only, never rsp_valid/rsp_data.
  assign accept_ok = !full || rsp_ready;

  // Grant selection. Reset is folded in here so the ready outputs and the
  // ALU drive are forced idle for as long as rst is held, not just after
  // the next edge.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!rst && accept_ok) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = prio;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid &&  grant_id;

  // Steer the winner onto the ALU; an idle ALU sees zeros and NOP so its
  // output is quiet and predictable.
  always_comb begin
    alu_in1     = 32'd0;
    alu_in2     = 32'd0;
    alu_control = ALU_NOP;
    if (grant_valid) begin
      if (grant_id) begin
        alu_in1     = req1_in1;
        alu_in2     = req1_in2;
        alu_control = req1_control;
      end else begin
        alu_in1     = req0_in1;
        alu_in2     = req0_in2;
        alu_control = req0_control;
      end
    end
  end

  // Response buffer and round-robin pointer. A grant always wins over a
  // drain so that a drain and a refill on the same edge leave the buffer
  // full with the new entry. After any grant the pointer moves to the other
  // requester, which covers both the contention and single-request cases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      buf_id   <= 1'b0;
      buf_data <= 32'd0;
      prio     <= 1'b0;
    end else if (grant_valid) begin
      full     <= 1'b1;
      buf_id   <= grant_id;
      buf_data <= alu_out;
      prio     <= !grant_id;
    end else if (full && rsp_ready) begin
      full     <= 1'b0;
    end
  end

  assign rsp_valid = full;
  assign rsp_id    = buf_id;
  assign rsp_data  = buf_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter. A small behavioural ALU closes the
// loop from alu_in1/alu_in2/alu_control back to alu_out. Inputs are driven
// 1 ns after the rising edge; combinational outputs are sampled 1 ns after
// that and registered outputs 1 ns after the next rising edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LTU = 4'h6;
  localparam logic [3:0] OP_NOP = 4'hF;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_control, req1_control;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_control;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_data;

  int compareCount;
  int mismatchCount;

  alu_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_in1     (req0_in1),
    .req0_in2     (req0_in2),
    .req0_control (req0_control),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_in1     (req1_in1),
    .req1_in2     (req1_in2),
    .req1_control (req1_control),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_control  (alu_control),
    .alu_out      (alu_out),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the shared ALU; unknown codes and NOP return 0.
  always_comb begin
    alu_out = 32'd0;
    case (alu_control)
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SUB:  alu_out = alu_in1 - alu_in2;
      OP_XOR:  alu_out = alu_in1 ^ alu_in2;
      OP_LTU:  alu_out = {31'd0, (alu_in1 < alu_in2)};
      default: alu_out = 32'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] c0,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] c1,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic rr);
    req0_valid   = v0;
    req0_control = c0;
    req0_in1     = a0;
    req0_in2     = b0;
    req1_valid   = v1;
    req1_control = c1;
    req1_in1     = a1;
    req1_in2     = b1;
    rsp_ready    = rr;
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, OP_NOP, 32'd0, 32'd0, 1'b1);
    #2;

    // Reset state: outputs idle even with a request pending.
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("reset_alu_control", {28'd0, alu_control}, {28'd0, OP_NOP});
    checkOutput("reset_alu_in1", alu_in1, 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);

    stepCycle();
    rst = 1'b0;

    // Single request: req0 ADD 5,7.
    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, OP_NOP, 32'd0, 32'd0, 1'b1);
    #1;
    checkOutput("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("single_req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("single_alu_in1", alu_in1, 32'd5);
    checkOutput("single_alu_ctrl", {28'd0, alu_control}, {28'd0, OP_ADD});
    stepCycle();
    applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_NOP, 32'd0, 32'd0, 1'b1);
    checkOutput("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("single_rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("single_rsp_data", rsp_data, 32'd12);
    stepCycle();
    checkOutput("single_drained", {31'd0, rsp_valid}, 32'd0);

    // One-sided streaming: req1 LTU 3,8 for four cycles.
    applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b1, OP_LTU, 32'd3, 32'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("stream_req1_ready", {31'd0, req1_ready}, 32'd1);
      stepCycle();
      checkOutput("stream_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("stream_rsp_id", {31'd0, rsp_id}, 32'd1);
      checkOutput("stream_rsp_data", rsp_data, 32'd1);
    end

    // Contention: prio is 0 after streaming, so grants go 0,1,0,1.
    applyStimulus(1'b1, OP_SUB, 32'd9, 32'd4, 1'b1, OP_XOR, 32'hF0, 32'h0F, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("contend_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("contend_req1_ready", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      stepCycle();
      checkOutput("contend_rsp_id", {31'd0, rsp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("contend_rsp_data", rsp_data, (i % 2 == 0) ? 32'd5 : 32'hFF);
    end

    // Stall: buffer holds id1/0xFF, consumer not ready for 3 cycles.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      stepCycle();
      checkOutput("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("stall_rsp_id", {31'd0, rsp_id}, 32'd1);
      checkOutput("stall_rsp_data", rsp_data, 32'hFF);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("unstall_req0_ready", {31'd0, req0_ready}, 32'd1);
    stepCycle();
    checkOutput("unstall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("unstall_rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("unstall_rsp_data", rsp_data, 32'd5);

    // Idle: no requests for five cycles; prio stays at 1.
    applyStimulus(1'b0, OP_SUB, 32'd9, 32'd4, 1'b0, OP_XOR, 32'hF0, 32'h0F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("idle_alu_control", {28'd0, alu_control}, {28'd0, OP_NOP});
      checkOutput("idle_alu_in1", alu_in1, 32'd0);
      stepCycle();
      checkOutput("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    applyStimulus(1'b1, OP_SUB, 32'd9, 32'd4, 1'b1, OP_XOR, 32'hF0, 32'h0F, 1'b1);
    #1;
    checkOutput("idle_prio_req1_ready", {31'd0, req1_ready}, 32'd1);
    checkOutput("idle_prio_req0_ready", {31'd0, req0_ready}, 32'd0);
    stepCycle();
    checkOutput("idle_prio_rsp_id", {31'd0, rsp_id}, 32'd1);

    // Reset mid-operation: fill the buffer via req0 (prio becomes 1), stall it.
    applyStimulus(1'b1, OP_SUB, 32'd9, 32'd4, 1'b0, OP_NOP, 32'd0, 32'd0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
    checkOutput("prerst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("asyncrst_rsp_data", rsp_data, 32'd0);
    applyStimulus(1'b1, OP_SUB, 32'd9, 32'd4, 1'b1, OP_XOR, 32'hF0, 32'h0F, 1'b1);
    #1;
    checkOutput("inrst_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("inrst_req1_ready", {31'd0, req1_ready}, 32'd0);
    checkOutput("inrst_alu_control", {28'd0, alu_control}, {28'd0, OP_NOP});
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("postrst_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("postrst_req1_ready", {31'd0, req1_ready}, 32'd0);
    stepCycle();
    checkOutput("postrst_rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("postrst_rsp_data", rsp_data, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount,
             mismatchCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports req0_valid/req1_valid, input, 1, requester n presents an operation.
REQ-004 SHALL have ports req0_ready/req1_ready, output, 1, operation of requester n is accepted this cycle.
REQ-005 SHALL have ports req0_in1/req0_in2/req1_in1/req1_in2, input, 32, operands of requester n.
REQ-006 SHALL have ports req0_control/req1_control, input, 4, ALU opcode of requester n, shared ALU control encoding.
REQ-007 SHALL have ports alu_in1/alu_in2 (output, 32) and alu_control (output, 4), driving the shared ALU.
REQ-008 SHALL have port alu_out, input, 32, combinational result of the shared ALU.
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1, winning requester index), rsp_data (output, 32).
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts the response.

Function
REQ-011 SHALL hold a one-entry response buffer (full flag, id, data) and a 1-bit round-robin pointer prio (requester with priority).
REQ-012 SHALL define accept_ok = !full | rsp_ready; no grant when accept_ok is 0.
REQ-013 SHALL grant, when accept_ok: sole valid requester if one valid; requester prio if both valid; none if neither.
REQ-014 SHALL assert reqN_ready only for the granted requester, combinationally, with no dependency of ready on the other port's ready.
REQ-015 SHALL drive alu_in1/alu_in2/alu_control from the granted requester in the grant cycle; with no grant, drive 0/0/NOP encoding.
REQ-016 SHALL, on a grant edge, capture alu_out into buffer data, winner index into id, set full; latency accept-to-rsp_valid exactly 1 cycle.
REQ-017 SHALL, on edge with full & rsp_ready and no grant, clear full; with simultaneous grant, replace entry and keep full (back-to-back throughput 1/cycle).
REQ-018 SHALL hold id/data/full unchanged while full & !rsp_ready (stall), regardless of request activity.
REQ-019 SHALL set rsp_valid = full, rsp_id = id, rsp_data = data directly from registers.
REQ-020 SHALL, on a grant with both requesters valid, set prio to the loser; on a grant with one valid, set prio to the non-granted index; prio unchanged when no grant.
REQ-021 SHALL not capture operands until the grant edge; requester may change operands freely while not ready.
REQ-022 SHALL treat opcodes outside the defined set as pass-through to the ALU (result as ALU returns, normally 0); no error flag.
REQ-023 SHALL contain no combinational path from rsp_ready to rsp_valid/rsp_data.

Reset
REQ-024 SHALL, on rst high, immediately clear full (rsp_valid=0), id=0, data=0, prio=0, independent of clk.
REQ-025 SHALL, while rst high, hold req0_ready=req1_ready=0 and alu_control=NOP, alu_in1=alu_in2=0.
REQ-026 SHALL discard any buffered or in-flight operation on reset mid-operation; first grant after release follows REQ-013 with prio=0.

Verification
REQ-027 SHALL cover single request: req0 ADD 5,7, rsp_ready=1 -> req0_ready=1 cycle N, rsp_valid=1, rsp_id=0, rsp_data=12 cycle N+1.
REQ-028 SHALL cover contention: both valid continuously (req0 SUB 9,4; req1 XOR 0xF0,0x0F), rsp_ready=1 -> grants alternate 0,1,0,1; responses 5,0xFF,5,0xFF.
REQ-029 SHALL cover stall: buffer full, rsp_ready=0 for 3 cycles, both valid -> no ready asserted, rsp_data stable; rsp_ready=1 -> drain and new grant same cycle.
REQ-030 SHALL cover one-sided streaming: req1 only, LTU 3,8 for 4 cycles, rsp_ready=1 -> 4 responses data=1, id=1, then prio=0.
REQ-031 SHALL cover reset mid-operation: rst asserted asynchronously while full -> rsp_valid falls before next clk edge; after release, req0 and req1 both valid -> req0 granted first.
REQ-032 SHALL cover idle: no valid for 5 cycles -> alu_control=NOP, no response, prio unchanged.
